// File: rtl/prbs_led_pkg.sv
// ---------------------------------------------------------------------------
// prbs_led_pkg
// Shared constants and helpers for the LED level/step and PRBS phase
// stepping blocks.
//   DIR_UP / DIR_DN      : encoding of the counter direction input
//   MODE_SAT / MODE_WRAP : encoding of the counter limit-behaviour input
//   clamp_val()          : clamp a value into [min_val, max_val]
// ---------------------------------------------------------------------------
package prbs_led_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // Operands are 17 bits so any counter up to 16 bits can be clamped without
  // overflow; callers zero-extend their operands and truncate the result.
  function automatic logic [16:0] clamp_val(input logic [16:0] value,
                                            input logic [16:0] min_val,
                                            input logic [16:0] max_val);
    logic [16:0] res;
    res = value;
    if (value < min_val) begin
      res = min_val;
    end else if (value > max_val) begin
      res = max_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_sat_updn.sv
// ---------------------------------------------------------------------------
// counter_sat_updn
// Parametrised up/down counter bounded to [MIN_VAL, MAX_VAL] that either
// saturates or wraps at the limits, with synchronous clear/load, registered
// limit flags, a one-cycle limit_hit pulse and a sticky overflow flag.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   one count step per cycle when high
//   dir        in   1 = up, 0 = down
//   wrap       in   0 = saturate at limits, 1 = wrap to opposite limit
//   clr        in   synchronous clear to RESET_VAL, also clears ovf
//   load       in   synchronous load of load_val (clamped into range)
//   load_val   in   [WIDTH] value to load
//   out        out  [WIDTH] registered counter value
//   at_max     out  registered, out == MAX_VAL
//   at_min     out  registered, out == MIN_VAL
//   limit_hit  out  registered pulse when a counting step lands on a limit
//   ovf        out  sticky, set when a step is attempted beyond a limit
//
// Priority per edge: clr > load > enable > hold. All outputs are registered.
// ---------------------------------------------------------------------------
module counter_sat_updn
  import prbs_led_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic             wrap,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             limit_hit,
  output logic             ovf
);

  // Parameter legality, rejected at elaboration.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("counter_sat_updn: WIDTH must be in 2..16");
  end
  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_bad_min
    $error("counter_sat_updn: need 0 <= MIN_VAL < MAX_VAL");
  end
  if (MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
    $error("counter_sat_updn: MAX_VAL exceeds 2**WIDTH-1");
  end
  if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("counter_sat_updn: RESET_VAL outside [MIN_VAL, MAX_VAL]");
  end

  localparam logic [WIDTH-1:0] L_MIN    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] L_MAX    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] L_RST    = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] L_ONE    = WIDTH'(1);
  localparam logic [WIDTH:0]   L_MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   L_ONE_X  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_at_max;
  logic             r_at_min;
  logic             r_hit;
  logic             r_ovf;

  logic [WIDTH:0]   w_up;
  logic [WIDTH-1:0] w_dn;
  logic [WIDTH-1:0] w_nxt_out;
  logic             w_nxt_ovf;
  logic             w_nxt_hit;

  always_comb begin
    // The increment is one bit wider so stepping past MAX_VAL is detected
    // before truncation, even when MAX_VAL == 2**WIDTH-1.
    w_up      = {1'b0, r_out} + L_ONE_X;
    w_dn      = r_out - L_ONE;
    w_nxt_out = r_out;
    w_nxt_ovf = r_ovf;
    w_nxt_hit = 1'b0;

    if (clr) begin
      w_nxt_out = L_RST;
      w_nxt_ovf = 1'b0;
    end else if (load) begin
      w_nxt_out = WIDTH'(clamp_val(17'(load_val), 17'(MIN_VAL), 17'(MAX_VAL)));
    end else if (enable) begin
      case (dir)
        DIR_UP: begin
          if (w_up <= L_MAX_X) begin
            w_nxt_out = w_up[WIDTH-1:0];
            w_nxt_hit = (w_up == L_MAX_X);
          end else begin
            w_nxt_ovf = 1'b1;
            case (wrap)
              MODE_WRAP: begin
                w_nxt_out = L_MIN;
                w_nxt_hit = 1'b1;
              end
              MODE_SAT: begin
                // Hold at MAX_VAL; an unchanged value is not a limit hit.
              end
            endcase
          end
        end
        DIR_DN: begin
          if (r_out > L_MIN) begin
            w_nxt_out = w_dn;
            w_nxt_hit = (w_dn == L_MIN);
          end else begin
            w_nxt_ovf = 1'b1;
            case (wrap)
              MODE_WRAP: begin
                w_nxt_out = L_MAX;
                w_nxt_hit = 1'b1;
              end
              MODE_SAT: begin
                // Hold at MIN_VAL; an unchanged value is not a limit hit.
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= L_RST;
      r_at_max <= (RESET_VAL == MAX_VAL);
      r_at_min <= (RESET_VAL == MIN_VAL);
      r_hit    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_out    <= w_nxt_out;
      // Flags are derived from the next value so they line up with out.
      r_at_max <= (w_nxt_out == L_MAX);
      r_at_min <= (w_nxt_out == L_MIN);
      r_hit    <= w_nxt_hit;
      r_ovf    <= w_nxt_ovf;
    end
  end

  assign out       = r_out;
  assign at_max    = r_at_max;
  assign at_min    = r_at_min;
  assign limit_hit = r_hit;
  assign ovf       = r_ovf;

endmodule

// File: doc/counter_sat_updn.md
Name: counter_sat_updn

Overview:
- Parametrised successor to the team's 2-bit saturating counter.
- Adds configurable width and limits, up/down direction, wrap-or-saturate mode, synchronous clear and load, limit flags and a sticky overflow flag.
- Drives LED level/step selection and PRBS phase stepping, in place of fixed 2-bit counters.

Parameters:
- WIDTH, 4, counter width in bits (range 2..16).
- MIN_VAL, 0, lower limit. Must satisfy 0 <= MIN_VAL < MAX_VAL.
- MAX_VAL, 2**WIDTH-1, upper limit. Must satisfy MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, MIN_VAL, value taken on reset and on clr. Must lie in [MIN_VAL, MAX_VAL].

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  count-step request, one step per cycle when high.
- dir  input  1  step direction: 1 = up, 0 = down.
- wrap  input  1  mode: 0 = saturate at limits, 1 = wrap to opposite limit.
- clr  input  1  synchronous clear to RESET_VAL; also clears ovf.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load; clamped into [MIN_VAL, MAX_VAL].
- out  output  WIDTH  counter value, registered.
- at_max  output  1  registered, high when out == MAX_VAL.
- at_min  output  1  registered, high when out == MIN_VAL.
- limit_hit  output  1  registered one-cycle pulse on a counting step that lands on a limit.
- ovf  output  1  sticky flag, set on any step attempted beyond a limit.

Behaviour:
- Reset (async, rst=1):
  - out = RESET_VAL, ovf = 0, limit_hit = 0.
  - at_max = (RESET_VAL == MAX_VAL), at_min = (RESET_VAL == MIN_VAL).
  - rst deasserting mid-operation resumes from RESET_VAL; no partial step is retained.
- Priority per clock edge: clr > load > enable > hold.
- clr: out <= RESET_VAL, ovf <= 0, limit_hit <= 0. load and enable are ignored that cycle.
- load:
  - out <= clamp(load_val): below MIN_VAL gives MIN_VAL, above MAX_VAL gives MAX_VAL.
  - limit_hit <= 0; ovf unchanged. enable is ignored that cycle.
- enable, dir=1:
  - out < MAX_VAL: out <= out+1.
  - out == MAX_VAL: wrap=0 holds at MAX_VAL; wrap=1 gives out <= MIN_VAL. ovf <= 1 in both modes.
- enable, dir=0:
  - out > MIN_VAL: out <= out-1.
  - out == MIN_VAL: wrap=0 holds at MIN_VAL; wrap=1 gives out <= MAX_VAL. ovf <= 1 in both modes.
- limit_hit:
  - Asserted the same cycle out is updated, only when an enabled step produces a new value equal to MIN_VAL or MAX_VAL.
  - This includes the wrap landing (wrap lands on a limit).
  - A saturated hold (value unchanged) does not assert limit_hit. Deasserted otherwise.
- at_max/at_min always reflect the registered out. Both are never high together, since MIN_VAL < MAX_VAL.
- Arithmetic: the next value is computed at WIDTH+1 bits and compared before truncation. No silent modular wrap at 2**WIDTH when MAX_VAL is below that.
- Latency: every input takes effect on out and the flags at the next rising edge. No combinational input-to-output paths.
- dir and wrap are sampled only when enable is high and neither clr nor load is active.

Decomposition:
- Shared package prbs_led_pkg:
  - constants DIR_UP=1'b1, DIR_DN=1'b0, MODE_SAT=1'b0, MODE_WRAP=1'b1.
  - function clamp_val(value, min, max).
- Parameter legality is checked at elaboration (assertion/initial check): MIN_VAL < MAX_VAL, MAX_VAL <= 2**WIDTH-1, RESET_VAL in range.
- No sub-module; the next-state logic is a single always block plus flag registers.

Test Plan (WIDTH=4, MIN_VAL=2, MAX_VAL=12, RESET_VAL=2 unless stated):
- Reset, then enable=1, dir=1, wrap=0 for 12 cycles:
  - out steps 2..12 and holds at 12.
  - limit_hit pulses once on the cycle out reaches 12; at_max=1.
  - ovf sets on the first cycle stepping beyond 12.
- Count down to out=2, then enable=1, dir=0, wrap=1:
  - out goes 2 to 12, limit_hit=1, ovf=1.
  - Next step gives 11, limit_hit=0.
- load=1, load_val=15 -> out=12, at_max=1. load_val=0 -> out=2, at_min=1. ovf unchanged both times.
- clr=1, load=1, enable=1 together with out=7, ovf=1 -> out=2, ovf=0, limit_hit=0.
- rst asserted asynchronously mid-count at out=9 -> out=2 immediately, before the next clk edge. Counting resumes at 3 after release.
- WIDTH=2, MIN_VAL=0, MAX_VAL=3, wrap=0, dir=1, 5 enables -> out 0,1,2,3,3. This matches the legacy 2-bit saturating behaviour.
